// File: rtl/clock_pkg.sv
// Shared encodings for the LCD clock: STATE bus values, button codes and menu items.
// Imported by the mode sequencer and the time/timezone set blocks.
package clock_pkg;

    typedef enum logic [3:0] {
        ST_INITIAL_DELAY = 4'b0000,
        ST_FUNCTION_SET  = 4'b0001,
        ST_INITIAL_SETUP = 4'b0010,
        ST_CLEAR_SCREEN  = 4'b0011,
        ST_SETUP         = 4'b0100,
        ST_TIME_SET      = 4'b0101,
        ST_TZ_SET        = 4'b0110,
        ST_LINE1         = 4'b1000,
        ST_LINE2         = 4'b1001
    } state_e;

    localparam logic [4:0] BTN_NONE   = 5'b00000;
    localparam logic [4:0] BTN_UP     = 5'b10000;
    localparam logic [4:0] BTN_DOWN   = 5'b01000;
    localparam logic [4:0] BTN_CENTER = 5'b00100;
    localparam logic [4:0] BTN_LEFT   = 5'b00010;
    localparam logic [4:0] BTN_RIGHT  = 5'b00001;

    localparam logic MENU_TIME = 1'b0;
    localparam logic MENU_TZ   = 1'b1;

endpackage

// File: rtl/clock_mode_ctrl_btn_edge.sv
// Rising-edge press detector for the 5-way buttons; press_valid flags a
// single-button press so chorded presses can be ignored by the consumer.
module btn_edge (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] buttons,
    output logic [4:0] press,
    output logic       press_valid
);

    logic [4:0] btn_prev_q;
    logic [4:0] btn_prev_d;

    always_comb begin
        btn_prev_d  = buttons;
        press       = (btn_prev_q ^ buttons) & buttons;
        press_valid = (press != '0) && ((press & (press - 5'd1)) == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev_q <= '0;
        end else begin
            btn_prev_q <= btn_prev_d;
        end
    end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode sequencer for the LCD clock: power-up command phases, LINE1/LINE2 refresh,
// hold-CENTER menu entry, menu selection and one-cycle load strobes from set flags.
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned INIT_DELAY_CYCLES = 100,
    parameter int unsigned CMD_CYCLES        = 4,
    parameter int unsigned LINE_CYCLES       = 8,
    parameter int unsigned HOLD_CYCLES       = 50,
    parameter int unsigned TIMEOUT_CYCLES    = 1000
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [4:0] BUTTONS,
    input  logic       TIME_SET_FLAG,
    input  logic       TZ_SET_FLAG,
    output logic [3:0] STATE,
    output logic       MENU_SEL,
    output logic       CLOCK_LOAD,
    output logic       TZ_LOAD
);

    localparam int unsigned DWELL_MAX =
        (INIT_DELAY_CYCLES > CMD_CYCLES) ?
            ((INIT_DELAY_CYCLES > LINE_CYCLES) ? INIT_DELAY_CYCLES : LINE_CYCLES) :
            ((CMD_CYCLES > LINE_CYCLES) ? CMD_CYCLES : LINE_CYCLES);
    localparam int unsigned DWELL_W = $clog2(DWELL_MAX + 1);
    localparam int unsigned HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned IDLE_W  = $clog2(TIMEOUT_CYCLES + 1);

    state_e              state_q, state_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic                menu_sel_q, menu_sel_d;
    logic                clock_load_q, clock_load_d;
    logic                tz_load_q, tz_load_d;
    logic                wait_release_q, wait_release_d;
    logic                time_flag_prev_q, tz_flag_prev_q;

    logic [4:0]          press;
    logic                press_valid;
    logic                dwell_done;
    logic                accepted;

    btn_edge u_btn_edge (
        .clk         (CLK),
        .rst_n       (RESETN),
        .buttons     (BUTTONS),
        .press       (press),
        .press_valid (press_valid)
    );

    always_comb begin
        dwell_done = 1'b0;
        case (state_q)
            ST_INITIAL_DELAY: dwell_done = (dwell_q == DWELL_W'(INIT_DELAY_CYCLES - 1));
            ST_FUNCTION_SET,
            ST_INITIAL_SETUP,
            ST_CLEAR_SCREEN:  dwell_done = (dwell_q == DWELL_W'(CMD_CYCLES - 1));
            ST_LINE1,
            ST_LINE2:         dwell_done = (dwell_q == DWELL_W'(LINE_CYCLES - 1));
            default:          dwell_done = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        menu_sel_d     = menu_sel_q;
        clock_load_d   = 1'b0;
        tz_load_d      = 1'b0;
        wait_release_d = wait_release_q;
        hold_d         = '0;
        idle_d         = '0;
        accepted       = press_valid && !((press == BTN_CENTER) && wait_release_q);

        case (state_q)
            ST_INITIAL_DELAY: if (dwell_done) state_d = ST_FUNCTION_SET;
            ST_FUNCTION_SET:  if (dwell_done) state_d = ST_INITIAL_SETUP;
            ST_INITIAL_SETUP: if (dwell_done) state_d = ST_CLEAR_SCREEN;
            ST_CLEAR_SCREEN:  if (dwell_done) state_d = ST_LINE1;
            ST_LINE1, ST_LINE2: begin
                // hold count spans LINE1/LINE2 swaps; only a non-CENTER input clears it
                if (BUTTONS == BTN_CENTER) hold_d = hold_q + 1'b1;
                if (dwell_done) state_d = (state_q == ST_LINE1) ? ST_LINE2 : ST_LINE1;
                if ((BUTTONS == BTN_CENTER) && (hold_q == HOLD_W'(HOLD_CYCLES - 1))) begin
                    state_d        = ST_SETUP;
                    wait_release_d = 1'b1;
                    menu_sel_d     = MENU_TIME;
                end
            end
            ST_SETUP: begin
                idle_d = idle_q + 1'b1;
                if (BUTTONS == BTN_NONE) wait_release_d = 1'b0;
                if (accepted) begin
                    idle_d = '0;
                    case (press)
                        BTN_UP, BTN_DOWN: menu_sel_d = ~menu_sel_q;
                        BTN_CENTER:       state_d = (menu_sel_q == MENU_TZ) ? ST_TZ_SET : ST_TIME_SET;
                        BTN_LEFT:         state_d = ST_CLEAR_SCREEN;
                        default:          ;
                    endcase
                end else if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_CLEAR_SCREEN;
                end
            end
            ST_TIME_SET: begin
                if (TIME_SET_FLAG && !time_flag_prev_q) begin
                    clock_load_d = 1'b1;
                    state_d      = ST_CLEAR_SCREEN;
                end
            end
            ST_TZ_SET: begin
                if (TZ_SET_FLAG && !tz_flag_prev_q) begin
                    tz_load_d = 1'b1;
                    state_d   = ST_CLEAR_SCREEN;
                end
            end
            default: state_d = ST_INITIAL_DELAY;
        endcase

        dwell_d = (state_d != state_q) ? '0 : dwell_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q          <= ST_INITIAL_DELAY;
            dwell_q          <= '0;
            hold_q           <= '0;
            idle_q           <= '0;
            menu_sel_q       <= MENU_TIME;
            clock_load_q     <= 1'b0;
            tz_load_q        <= 1'b0;
            wait_release_q   <= 1'b0;
            time_flag_prev_q <= 1'b0;
            tz_flag_prev_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            dwell_q          <= dwell_d;
            hold_q           <= hold_d;
            idle_q           <= idle_d;
            menu_sel_q       <= menu_sel_d;
            clock_load_q     <= clock_load_d;
            tz_load_q        <= tz_load_d;
            wait_release_q   <= wait_release_d;
            time_flag_prev_q <= TIME_SET_FLAG;
            tz_flag_prev_q   <= TZ_SET_FLAG;
        end
    end

    assign STATE      = state_q;
    assign MENU_SEL   = menu_sel_q;
    assign CLOCK_LOAD = clock_load_q;
    assign TZ_LOAD    = tz_load_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Self-checking bench for clock_mode_ctrl: randomized button noise and hold lengths
// against a timeline model derived from the phase durations.
module tb_clock_mode_ctrl;

    localparam int INIT_C = 100;
    localparam int CMD_C  = 4;
    localparam int LINE_C = 8;
    localparam int HOLD_C = 50;
    localparam int TOUT_C = 1000;

    localparam logic [4:0] B_UP     = 5'b10000;
    localparam logic [4:0] B_DOWN   = 5'b01000;
    localparam logic [4:0] B_CENTER = 5'b00100;
    localparam logic [4:0] B_RIGHT  = 5'b00001;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic [4:0] BUTTONS = '0;
    logic       TIME_SET_FLAG = 1'b0;
    logic       TZ_SET_FLAG = 1'b0;
    logic [3:0] STATE;
    logic       MENU_SEL;
    logic       CLOCK_LOAD;
    logic       TZ_LOAD;

    int tests = 0;
    int fails = 0;
    int line_n = 0;   // cycles since the current LINE1 entry

    always #5 CLK = ~CLK;

    clock_mode_ctrl #(
        .INIT_DELAY_CYCLES (INIT_C),
        .CMD_CYCLES        (CMD_C),
        .LINE_CYCLES       (LINE_C),
        .HOLD_CYCLES       (HOLD_C),
        .TIMEOUT_CYCLES    (TOUT_C)
    ) dut (
        .CLK           (CLK),
        .RESETN        (RESETN),
        .BUTTONS       (BUTTONS),
        .TIME_SET_FLAG (TIME_SET_FLAG),
        .TZ_SET_FLAG   (TZ_SET_FLAG),
        .STATE         (STATE),
        .MENU_SEL      (MENU_SEL),
        .CLOCK_LOAD    (CLOCK_LOAD),
        .TZ_LOAD       (TZ_LOAD)
    );

    function automatic logic [3:0] line_state(input int n);
        return (((n / LINE_C) % 2) == 1) ? 4'b1001 : 4'b1000;
    endfunction

    function automatic logic [3:0] boot_state(input int n);
        if (n < INIT_C) return 4'b0000;
        if (n < INIT_C + CMD_C) return 4'b0001;
        if (n < INIT_C + 2 * CMD_C) return 4'b0010;
        if (n < INIT_C + 3 * CMD_C) return 4'b0011;
        return line_state(n - INIT_C - 3 * CMD_C);
    endfunction

    function automatic logic [4:0] noise();
        logic [4:0] v;
        v = 5'($urandom_range(0, 31));
        if (v == B_CENTER) v = '0;
        return v;
    endfunction

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
        line_n++;
    endtask

    task automatic test_reset();
        RESETN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            BUTTONS = noise();
            step();
            tests++;
            if (STATE !== 4'b0000 || MENU_SEL !== 1'b0 || CLOCK_LOAD !== 1'b0 || TZ_LOAD !== 1'b0) begin
                fails++;
                $display("FAIL reset: STATE=%b MENU_SEL=%b CLOCK_LOAD=%b TZ_LOAD=%b required 0000/0/0/0",
                         STATE, MENU_SEL, CLOCK_LOAD, TZ_LOAD);
            end
        end
    endtask

    task automatic test_powerup(input int ncyc);
        RESETN = 1'b1;
        for (int n = 0; n < ncyc; n++) begin
            tests++;
            if (STATE !== boot_state(n)) begin
                fails++;
                $display("FAIL powerup[%0d]: STATE=%b required %b", n, STATE, boot_state(n));
            end
            BUTTONS = noise();
            step();
        end
        BUTTONS = '0;
        line_n = ncyc - (INIT_C + 3 * CMD_C);
    endtask

    task automatic enter_setup();
        BUTTONS = B_CENTER;
        for (int i = 0; i < HOLD_C - 1; i++) begin
            step();
            tests++;
            if (STATE !== line_state(line_n)) begin
                fails++;
                $display("FAIL hold_line[%0d]: STATE=%b required %b", i, STATE, line_state(line_n));
            end
        end
        step();
        tests++;
        if (STATE !== 4'b0100 || MENU_SEL !== 1'b0) begin
            fails++;
            $display("FAIL hold_enter: STATE=%b MENU_SEL=%b required 0100/0", STATE, MENU_SEL);
        end
    endtask

    task automatic test_hold_short();
        int len;
        len = $urandom_range(1, HOLD_C - 1);
        BUTTONS = B_CENTER;
        for (int i = 0; i < len; i++) step();
        BUTTONS = '0;
        step();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (STATE !== line_state(line_n)) begin
                fails++;
                $display("FAIL hold_short(len=%0d): STATE=%b required %b", len, STATE, line_state(line_n));
            end
            step();
        end
    endtask

    task automatic test_hold_enter();
        int extra;
        enter_setup();
        extra = $urandom_range(1, 5);
        for (int i = 0; i < extra; i++) step();
        BUTTONS = B_RIGHT;
        step();
        BUTTONS = B_CENTER;
        step();
        tests++;
        if (STATE !== 4'b0100 || MENU_SEL !== 1'b0) begin
            fails++;
            $display("FAIL hold_no_select: STATE=%b MENU_SEL=%b required 0100/0", STATE, MENU_SEL);
        end
        BUTTONS = '0;
        step();
    endtask

    task automatic press(input logic [4:0] code);
        BUTTONS = code;
        step();
        BUTTONS = '0;
    endtask

    task automatic check_exit(input string name);
        for (int i = 0; i < CMD_C - 1; i++) begin
            step();
            tests++;
            if (STATE !== 4'b0011 || CLOCK_LOAD !== 1'b0 || TZ_LOAD !== 1'b0) begin
                fails++;
                $display("FAIL %s_clear[%0d]: STATE=%b CL=%b TZ=%b required 0011/0/0", name, i, STATE, CLOCK_LOAD, TZ_LOAD);
            end
        end
        step();
        line_n = 0;
        tests++;
        if (STATE !== 4'b1000) begin
            fails++;
            $display("FAIL %s_line1: STATE=%b required 1000", name, STATE);
        end
    endtask

    task automatic test_menu_time();
        logic sel;
        int np, k;
        sel = 1'b0;
        np = $urandom_range(2, 6);
        for (int i = 0; i < np; i++) begin
            BUTTONS = ($urandom_range(0, 1) == 1) ? B_UP : B_DOWN;
            step();
            sel = ~sel;
            tests++;
            if (MENU_SEL !== sel) begin
                fails++;
                $display("FAIL menu_toggle[%0d]: MENU_SEL=%b required %b", i, MENU_SEL, sel);
            end
            BUTTONS = '0;
            step();
        end
        if (sel) begin
            press(B_UP);
            sel = 1'b0;
            step();
        end
        press(B_CENTER);
        tests++;
        if (STATE !== 4'b0101) begin
            fails++;
            $display("FAIL time_enter: STATE=%b required 0101", STATE);
        end
        k = $urandom_range(3, 12);
        for (int i = 0; i < k; i++) begin
            BUTTONS = noise();
            step();
            tests++;
            if (STATE !== 4'b0101 || CLOCK_LOAD !== 1'b0) begin
                fails++;
                $display("FAIL time_wait[%0d]: STATE=%b CL=%b required 0101/0", i, STATE, CLOCK_LOAD);
            end
        end
        BUTTONS = '0;
        TIME_SET_FLAG = 1'b1;
        step();
        tests++;
        if (STATE !== 4'b0011 || CLOCK_LOAD !== 1'b1 || TZ_LOAD !== 1'b0) begin
            fails++;
            $display("FAIL time_load: STATE=%b CL=%b TZ=%b required 0011/1/0", STATE, CLOCK_LOAD, TZ_LOAD);
        end
        check_exit("time");
    endtask

    task automatic test_tz_stale();
        int k;
        TZ_SET_FLAG = 1'b1;
        enter_setup();
        BUTTONS = '0;
        step();
        press(B_DOWN);
        tests++;
        if (MENU_SEL !== 1'b1) begin
            fails++;
            $display("FAIL tz_menu: MENU_SEL=%b required 1", MENU_SEL);
        end
        step();
        press(B_CENTER);
        tests++;
        if (STATE !== 4'b0110) begin
            fails++;
            $display("FAIL tz_enter: STATE=%b required 0110", STATE);
        end
        k = $urandom_range(3, 12);
        for (int i = 0; i < k; i++) begin
            step();
            tests++;
            if (STATE !== 4'b0110 || TZ_LOAD !== 1'b0) begin
                fails++;
                $display("FAIL tz_stale[%0d]: STATE=%b TZ=%b required 0110/0", i, STATE, TZ_LOAD);
            end
        end
        TZ_SET_FLAG = 1'b0;
        step();
        TZ_SET_FLAG = 1'b1;
        step();
        tests++;
        if (STATE !== 4'b0011 || TZ_LOAD !== 1'b1 || CLOCK_LOAD !== 1'b0) begin
            fails++;
            $display("FAIL tz_load: STATE=%b TZ=%b CL=%b required 0011/1/0", STATE, TZ_LOAD, CLOCK_LOAD);
        end
        check_exit("tz");
    endtask

    task automatic test_timeout();
        enter_setup();
        BUTTONS = '0;
        step();
        BUTTONS = B_UP | B_DOWN;
        step();
        BUTTONS = '0;
        tests++;
        if (MENU_SEL !== 1'b0) begin
            fails++;
            $display("FAIL chord_ignored: MENU_SEL=%b required 0", MENU_SEL);
        end
        for (int k = 3; k < TOUT_C; k++) step();
        tests++;
        if (STATE !== 4'b0100) begin
            fails++;
            $display("FAIL timeout_early: STATE=%b required 0100", STATE);
        end
        step();
        tests++;
        if (STATE !== 4'b0011) begin
            fails++;
            $display("FAIL timeout_exit: STATE=%b required 0011", STATE);
        end
        check_exit("timeout");
    endtask

    task automatic test_async_reset();
        TIME_SET_FLAG = 1'b0;
        enter_setup();
        BUTTONS = '0;
        step();
        press(B_CENTER);
        tests++;
        if (STATE !== 4'b0101) begin
            fails++;
            $display("FAIL rst_time_enter: STATE=%b required 0101", STATE);
        end
        TIME_SET_FLAG = 1'b1;
        @(posedge CLK);
        #1;
        tests++;
        if (CLOCK_LOAD !== 1'b1) begin
            fails++;
            $display("FAIL rst_preload: CLOCK_LOAD=%b required 1", CLOCK_LOAD);
        end
        RESETN = 1'b0;
        #1;
        tests++;
        if (STATE !== 4'b0000 || CLOCK_LOAD !== 1'b0 || TZ_LOAD !== 1'b0 || MENU_SEL !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: STATE=%b CL=%b TZ=%b MENU=%b required 0000/0/0/0",
                     STATE, CLOCK_LOAD, TZ_LOAD, MENU_SEL);
        end
        TIME_SET_FLAG = 1'b0;
        @(negedge CLK);
        step();
        test_powerup(INIT_C + 3 * CMD_C + 2 * LINE_C);
    endtask

    initial begin
        test_reset();
        test_powerup(INIT_C + 3 * CMD_C + 6 * LINE_C);
        test_hold_short();
        test_hold_enter();
        test_menu_time();
        test_tz_stale();
        test_timeout();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
- Top-level mode sequencer for the LCD clock. Generates the shared 4-bit STATE bus consumed by the time-set, timezone-set and LCD driver blocks.
- Sequences the LCD power-up command phases, then a LINE1/LINE2 refresh loop.
- Handles menu entry and selection from the 5-way buttons.
- Converts completion flags from the set blocks into one-cycle load strobes for the clock counter and the timezone register.

Parameters:
- INIT_DELAY_CYCLES, 100, dwell in INITIAL_DELAY after reset.
- CMD_CYCLES, 4, dwell in each of FUNCTION_SET, INITIAL_SETUP, CLEAR_SCREEN.
- LINE_CYCLES, 8, dwell in each of LINE1 and LINE2.
- HOLD_CYCLES, 50, continuous CENTER-only cycles needed to enter SETUP.
- TIMEOUT_CYCLES, 1000, idle cycles in SETUP before automatic exit.

Ports:
- CLK  in  1  system clock.
- RESETN  in  1  reset.
- BUTTONS  in  5  {UP,DOWN,CENTER,LEFT,RIGHT}, bit4..bit0, level, synchronous to CLK.
- TIME_SET_FLAG  in  1  from time-set block; rises when the user confirms a time.
- TZ_SET_FLAG  in  1  from timezone-set block; rises when the user confirms a zone.
- STATE  out  4  current mode/LCD phase.
- MENU_SEL  out  1  highlighted menu item: 0 = time, 1 = timezone.
- CLOCK_LOAD  out  1  one-cycle strobe: clock counter loads TIME_SETDATA.
- TZ_LOAD  out  1  one-cycle strobe: timezone register loads the new zone.

Behaviour:
- Clocking and reset: single clock, posedge CLK. Reset is asynchronous, active-low on RESETN.
- Reset values: STATE = INITIAL_DELAY (0000), MENU_SEL = 0, CLOCK_LOAD = 0, TZ_LOAD = 0. All counters, btn_prev, flag_prev and wait_release are 0.
- Encodings:
  - STATE: INITIAL_DELAY 0000, FUNCTION_SET 0001, INITIAL_SETUP 0010, CLEAR_SCREEN 0011, SETUP 0100, TIME_SET 0101, TZ_SET 0110, LINE1 1000, LINE2 1001.
  - Buttons: UP 10000, DOWN 01000, CENTER 00100, LEFT 00010, RIGHT 00001.
- Button edges:
  - press = (btn_prev ^ BUTTONS) & BUTTONS; btn_prev <= BUTTONS every cycle.
  - A press is acted on only when it exactly equals one button code; multi-bit presses are ignored.
- Dwell counter: one shared counter, cleared on every STATE change. A transition fires in the cycle the counter equals limit-1, so a phase lasts exactly its limit in cycles.
- Power-up sequence: INITIAL_DELAY (INIT_DELAY_CYCLES) -> FUNCTION_SET -> INITIAL_SETUP -> CLEAR_SCREEN (CMD_CYCLES each) -> LINE1.
- Refresh loop: LINE1 -> LINE2 -> LINE1 ..., LINE_CYCLES each.
- Entering SETUP:
  - In LINE1/LINE2, hold counter increments while BUTTONS == CENTER and clears otherwise.
  - When it reaches HOLD_CYCLES-1: go to SETUP, set wait_release = 1, MENU_SEL = 0.
  - The hold counter is not cleared by LINE1<->LINE2 alternation.
- SETUP:
  - wait_release clears when BUTTONS == 0. A CENTER press is ignored while wait_release = 1.
  - UP or DOWN press: MENU_SEL toggles.
  - CENTER press: go to TIME_SET if MENU_SEL = 0, else TZ_SET.
  - LEFT press: go to CLEAR_SCREEN. RIGHT press: no action.
  - Idle counter clears on any accepted press and increments otherwise. At TIMEOUT_CYCLES-1, go to CLEAR_SCREEN.
- TIME_SET: buttons are ignored (the time-set block owns them). On a rising edge of TIME_SET_FLAG (flag_prev = 0, flag = 1): CLOCK_LOAD = 1 for exactly that cycle, next STATE = CLEAR_SCREEN. No timeout.
- TZ_SET: same as TIME_SET, using TZ_SET_FLAG and TZ_LOAD.
- Flag edge tracking: flag_prev registers update every cycle in all states. A flag already high on entry, left over from the previous session, does not fire; only a fresh 0->1 edge does.
- Exit path: CLEAR_SCREEN always dwells CMD_CYCLES before returning to LINE1.
- Strobe rules: CLOCK_LOAD and TZ_LOAD are registered and never high simultaneously. Each is high at most one cycle per session.
- Mid-operation reset: RESETN low in any state returns immediately to the reset values and restarts the full power-up sequence.

Decomposition:
- Package clock_pkg: STATE encodings, button codes, MENU_TIME/MENU_TZ constants. The time-set and timezone-set blocks must import these instead of local copies.
- Sub-module btn_edge: per-cycle press detection plus the one-hot-valid output. Reusable by the set blocks.

Test Plan (defaults unless stated):
- Power-up: release reset.
  - STATE = 0000 for 100 cycles, then 0001, 0010, 0011 for 4 cycles each, then 1000.
  - STATE alternates 1000/1001 every 8 cycles.
- Hold entry: CENTER held 49 cycles then released -> stays in LINE loop. CENTER held 50 cycles -> STATE = 0100 with MENU_SEL = 0, and the held CENTER is not taken as a selection.
- Menu select and time load:
  - In SETUP, release all buttons, press DOWN -> MENU_SEL = 1; press UP -> MENU_SEL = 0; press CENTER -> STATE = 0101.
  - Raise TIME_SET_FLAG -> CLOCK_LOAD high exactly 1 cycle, STATE = 0011, then 1000 after 4 cycles.
- Timezone path and stale flag:
  - Enter TZ_SET with TZ_SET_FLAG already 1 -> no TZ_LOAD.
  - Drop the flag to 0, raise it to 1 -> TZ_LOAD pulses once, CLOCK_LOAD stays 0.
- Invalid presses and timeout: in SETUP press UP+DOWN together -> MENU_SEL unchanged. Then with no presses for 1000 cycles -> STATE = 0011.
- Async reset: assert RESETN low during TIME_SET -> STATE = 0000, all strobes 0 in the same cycle, power-up sequence restarts.
